gt_reset_sequencer: RTL and testbench

//  Initiator side of the GT reset handshake for the 2x100GbE DCMAC path. Drives

---
 rtl/gt_reset_pkg.sv | 27 ++
 rtl/gt_rx_port_reset.sv | 94 +++++++++
 rtl/gt_reset_sequencer.sv | 175 +++++++++++++++++
 tb/tb_gt_reset_sequencer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gt_reset_pkg.sv
// gt_reset_pkg: state encodings and sizing helpers shared by the GT reset sequencer.
package gt_reset_pkg;

  // Top-level sequencing states: full GT reset pulse, wait for done, running, gave up.
  typedef enum logic [1:0] {
    ALL_ASSERT = 2'd0,
    ALL_WAIT   = 2'd1,
    RUN        = 2'd2,
    FAIL       = 2'd3
  } top_state_e;

  // Per-port rx datapath recovery states.
  typedef enum logic [1:0] {
    P_IDLE  = 2'd0,
    P_PULSE = 2'd1,
    P_WAIT  = 2'd2
  } port_state_e;

  localparam int unsigned RETRY_W   = 4;
  localparam int unsigned RECOVER_W = 16;

  // Timers must be able to hold TIMEOUT_CYCLES itself without wrapping.
  function automatic int unsigned timer_width(input int unsigned timeout_cycles);
    return $clog2(timeout_cycles + 1);
  endfunction

endpackage

// File: rtl/gt_rx_port_reset.sv
// gt_rx_port_reset: per-port rx datapath reset FSM with its own pulse/timeout timer.
// Only active while the top sequencer is (or stays) in RUN; otherwise held in P_IDLE.
module gt_rx_port_reset
  import gt_reset_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES   = 64,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run_i,
  input  logic req_i,
  input  logic rx_done_i,
  output logic rx_reset_o,
  output logic idle_o,
  output logic recovered_o,
  output logic escalate_o
);

  localparam int unsigned TW = timer_width(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] PULSE_LAST   = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  port_state_e   state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          rx_reset_q, rx_reset_d;
  logic          rx_done_q;
  logic          rx_done_fall;

  assign rx_done_fall = rx_done_q & ~rx_done_i;

  // Recovery completes on done, or gives up and asks the top for a full reset on timeout.
  assign idle_o      = (state_q == P_IDLE);
  assign recovered_o = (state_q == P_WAIT) & rx_done_i;
  assign escalate_o  = (state_q == P_WAIT) & ~rx_done_i & (timer_q == TIMEOUT_LAST);
  assign rx_reset_o  = rx_reset_q;

  // Next-state logic: pulse the rx datapath reset, then wait for done within the timeout.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    rx_reset_d = 1'b0;
    if (!run_i) begin
      state_d = P_IDLE;
      timer_d = '0;
    end else begin
      unique case (state_q)
        P_IDLE: begin
          if (req_i || rx_done_fall) begin
            state_d = P_PULSE;
            timer_d = '0;
          end
        end
        P_PULSE: begin
          if (timer_q == PULSE_LAST) begin
            state_d = P_WAIT;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        P_WAIT: begin
          if (rx_done_i || (timer_q == TIMEOUT_LAST)) begin
            state_d = P_IDLE;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        default: begin
          state_d = P_IDLE;
          timer_d = '0;
        end
      endcase
    end
    rx_reset_d = (state_d == P_PULSE);
  end

  // State, timer, registered reset output and the rx_done copy used for edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= P_IDLE;
      timer_q    <= '0;
      rx_reset_q <= 1'b0;
      rx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      rx_reset_q <= rx_reset_d;
      rx_done_q  <= rx_done_i;
    end
  end

endmodule

// File: rtl/gt_reset_sequencer.sv
// gt_reset_sequencer: initiator side of the DCMAC GT reset handshake.
// Runs the full GT reset with retries, hands per-port rx recovery to gt_rx_port_reset,
// and reports link status, retry and recovery counts. All outputs come from flops.
module gt_reset_sequencer
  import gt_reset_pkg::*;
#(
  parameter int unsigned PORTS          = 2,
  parameter int unsigned PULSE_CYCLES   = 64,
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic             s_axi_clk,
  input  logic             s_axi_aresetn,
  input  logic             sw_reset_all,
  input  logic [PORTS-1:0] sw_reset_rx_datapath,
  input  logic [PORTS-1:0] gt_rx_reset_done,
  input  logic [PORTS-1:0] gt_tx_reset_done,
  output logic             user_gt_reset_all,
  output logic [PORTS-1:0] user_gt_reset_rx_datapath,
  output logic [PORTS-1:0] link_up,
  output logic             busy,
  output logic             fail,
  output logic [3:0]       retry_count,
  output logic [15:0]      rx_recover_count
);

  localparam int unsigned TW = timer_width(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]        PULSE_LAST   = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0]        TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0]   RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);
  localparam logic [RECOVER_W-1:0] RECOVER_MAX  = '1;

  top_state_e           state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic [RECOVER_W-1:0] recover_q, recover_d;
  logic                 reset_all_q, reset_all_d;
  logic                 busy_q, busy_d;
  logic                 fail_q, fail_d;
  logic [PORTS-1:0]     link_up_q, link_up_d;
  logic [PORTS-1:0]     tx_done_q;

  logic                 port_run;
  logic [PORTS-1:0]     port_idle;
  logic [PORTS-1:0]     port_recovered;
  logic [PORTS-1:0]     port_escalate;
  logic [PORTS-1:0]     port_rx_reset;
  logic [PORTS-1:0]     tx_done_fall;
  logic                 all_done;

  assign tx_done_fall = tx_done_q & ~gt_tx_reset_done;
  assign all_done     = (&gt_tx_reset_done) & (&gt_rx_reset_done);

  // Ports follow the top's next state so a port never starts a pulse on the
  // same edge that the top leaves RUN (sw_reset_all, tx loss or escalation).
  assign port_run = (state_d == RUN);

  for (genvar p = 0; p < PORTS; p++) begin : gen_port
    gt_rx_port_reset #(
      .PULSE_CYCLES   (PULSE_CYCLES),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_port (
      .clk_i       (s_axi_clk),
      .rst_ni      (s_axi_aresetn),
      .run_i       (port_run),
      .req_i       (sw_reset_rx_datapath[p]),
      .rx_done_i   (gt_rx_reset_done[p]),
      .rx_reset_o  (port_rx_reset[p]),
      .idle_o      (port_idle[p]),
      .recovered_o (port_recovered[p]),
      .escalate_o  (port_escalate[p])
    );
  end

  // Top sequencing: pulse, wait with retry/timeout, run, fail; sw_reset_all overrides everything.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    retry_d = retry_q;
    unique case (state_q)
      ALL_ASSERT: begin
        if (timer_q == PULSE_LAST) begin
          state_d = ALL_WAIT;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ALL_WAIT: begin
        if (all_done) begin
          state_d = RUN;
          timer_d = '0;
        end else if (timer_q == TIMEOUT_LAST) begin
          timer_d = '0;
          if (retry_q < RETRY_LIMIT) begin
            retry_d = retry_q + 1'b1;
            state_d = ALL_ASSERT;
          end else begin
            state_d = FAIL;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RUN: begin
        if ((|tx_done_fall) || (|port_escalate)) begin
          state_d = ALL_ASSERT;
          timer_d = '0;
        end
      end
      FAIL: begin
        state_d = FAIL;
      end
      default: begin
        state_d = ALL_ASSERT;
        timer_d = '0;
      end
    endcase
    if (sw_reset_all) begin
      state_d = ALL_ASSERT;
      timer_d = '0;
      retry_d = '0;
    end
  end

  // Registered outputs derived from the next state, link status and the saturating recovery count.
  always_comb begin
    reset_all_d = (state_d == ALL_ASSERT);
    busy_d      = (state_d == ALL_ASSERT) || (state_d == ALL_WAIT);
    fail_d      = (state_d == FAIL);
    link_up_d   = '0;
    recover_d   = recover_q;
    for (int p = 0; p < PORTS; p++) begin
      link_up_d[p] = (state_q == RUN) && port_idle[p] &&
                     gt_rx_reset_done[p] && gt_tx_reset_done[p];
      if (port_recovered[p] && (recover_d != RECOVER_MAX)) begin
        recover_d = recover_d + 1'b1;
      end
    end
  end

  // Top-level state, counters and output registers.
  always_ff @(posedge s_axi_clk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q     <= ALL_ASSERT;
      timer_q     <= '0;
      retry_q     <= '0;
      recover_q   <= '0;
      reset_all_q <= 1'b1;
      busy_q      <= 1'b1;
      fail_q      <= 1'b0;
      link_up_q   <= '0;
      tx_done_q   <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      recover_q   <= recover_d;
      reset_all_q <= reset_all_d;
      busy_q      <= busy_d;
      fail_q      <= fail_d;
      link_up_q   <= link_up_d;
      tx_done_q   <= gt_tx_reset_done;
    end
  end

  assign user_gt_reset_all         = reset_all_q;
  assign user_gt_reset_rx_datapath = port_rx_reset;
  assign link_up                   = link_up_q;
  assign busy                      = busy_q;
  assign fail                      = fail_q;
  assign retry_count               = retry_q;
  assign rx_recover_count          = recover_q;

endmodule

// File: tb/tb_gt_reset_sequencer.sv
// tb_gt_reset_sequencer: directed scenarios for the GT reset sequencer with hand-computed expectations.
module tb_gt_reset_sequencer;

  localparam int PULSE   = 8;
  localparam int TIMEOUT = 100;
  localparam int RETRIES = 2;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        swAll = 1'b0;
  logic [1:0]  swRx = 2'b00;
  logic [1:0]  rxDone = 2'b00;
  logic [1:0]  txDone = 2'b00;
  logic        resetAll;
  logic [1:0]  rxDp;
  logic [1:0]  linkUp;
  logic        busyO;
  logic        failO;
  logic [3:0]  retryCnt;
  logic [15:0] recCnt;

  int compared = 0;
  int mismatched = 0;

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  gt_reset_sequencer #(
    .PORTS          (2),
    .PULSE_CYCLES   (PULSE),
    .TIMEOUT_CYCLES (TIMEOUT),
    .MAX_RETRIES    (RETRIES)
  ) dut (
    .s_axi_clk                 (clk),
    .s_axi_aresetn             (rstN),
    .sw_reset_all              (swAll),
    .sw_reset_rx_datapath      (swRx),
    .gt_rx_reset_done          (rxDone),
    .gt_tx_reset_done          (txDone),
    .user_gt_reset_all         (resetAll),
    .user_gt_reset_rx_datapath (rxDp),
    .link_up                   (linkUp),
    .busy                      (busyO),
    .fail                      (failO),
    .retry_count               (retryCnt),
    .rx_recover_count          (recCnt)
  );

  // Advance one clock; inputs are driven and outputs sampled 1 unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    repeat (3) step();
    compared++; if (resetAll !== 1'b1) begin mismatched++; $display("[TB] FAIL rst_reset_all: got %b want 1", resetAll); end
    compared++; if (busyO !== 1'b1) begin mismatched++; $display("[TB] FAIL rst_busy: got %b want 1", busyO); end
    compared++; if (failO !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_fail: got %b want 0", failO); end
    compared++; if (rxDp !== 2'b00) begin mismatched++; $display("[TB] FAIL rst_rx_dp: got %b want 00", rxDp); end
    compared++; if (linkUp !== 2'b00) begin mismatched++; $display("[TB] FAIL rst_link: got %b want 00", linkUp); end
    compared++; if (retryCnt !== 4'd0) begin mismatched++; $display("[TB] FAIL rst_retry: got %0d want 0", retryCnt); end
    compared++; if (recCnt !== 16'd0) begin mismatched++; $display("[TB] FAIL rst_recover: got %0d want 0", recCnt); end
  endtask

  task automatic test_bringup();
    logic want;
    rstN = 1'b1;
    for (int k = 1; k <= PULSE; k++) begin
      step();
      want = (k < PULSE);
      compared++; if (resetAll !== want) begin mismatched++; $display("[TB] FAIL bringup_pulse_c%0d: got %b want %b", k, resetAll, want); end
    end
    compared++; if (busyO !== 1'b1) begin mismatched++; $display("[TB] FAIL bringup_busy_wait: got %b want 1", busyO); end
    repeat (20) step();
    rxDone = 2'b11;
    txDone = 2'b11;
    step();
    compared++; if (linkUp !== 2'b00) begin mismatched++; $display("[TB] FAIL bringup_link_c21: got %b want 00", linkUp); end
    compared++; if (busyO !== 1'b0) begin mismatched++; $display("[TB] FAIL bringup_busy_run: got %b want 0", busyO); end
    step();
    compared++; if (linkUp !== 2'b11) begin mismatched++; $display("[TB] FAIL bringup_link_c22: got %b want 11", linkUp); end
    compared++; if (retryCnt !== 4'd0) begin mismatched++; $display("[TB] FAIL bringup_retry: got %0d want 0", retryCnt); end
  endtask

  task automatic test_rx_recover();
    rxDone[1] = 1'b0;
    step();
    compared++; if (rxDp !== 2'b10) begin mismatched++; $display("[TB] FAIL recover_pulse_start: got %b want 10", rxDp); end
    for (int k = 1; k < PULSE; k++) begin
      step();
      compared++; if (rxDp !== 2'b10) begin mismatched++; $display("[TB] FAIL recover_pulse_c%0d: got %b want 10", k, rxDp); end
      compared++; if (linkUp[0] !== 1'b1) begin mismatched++; $display("[TB] FAIL recover_link0_c%0d: got %b want 1", k, linkUp[0]); end
    end
    step();
    compared++; if (rxDp !== 2'b00) begin mismatched++; $display("[TB] FAIL recover_pulse_end: got %b want 00", rxDp); end
    step();
    rxDone[1] = 1'b1;
    step();
    compared++; if (recCnt !== 16'd1) begin mismatched++; $display("[TB] FAIL recover_count: got %0d want 1", recCnt); end
    compared++; if (linkUp !== 2'b01) begin mismatched++; $display("[TB] FAIL recover_link_lat: got %b want 01", linkUp); end
    step();
    compared++; if (linkUp !== 2'b11) begin mismatched++; $display("[TB] FAIL recover_link_back: got %b want 11", linkUp); end
    compared++; if (busyO !== 1'b0) begin mismatched++; $display("[TB] FAIL recover_busy: got %b want 0", busyO); end
  endtask

  task automatic test_retry_fail();
    int cyc;
    int rises;
    int riseAt [3];
    int retryAt [3];
    logic prev;
    logic sawRxDp;
    cyc = 0;
    rises = 0;
    sawRxDp = 1'b0;
    prev = resetAll;
    for (int i = 0; i < 3; i++) begin
      riseAt[i] = -1;
      retryAt[i] = -1;
    end
    rxDone = 2'b00;
    txDone = 2'b00;
    while (failO !== 1'b1 && cyc < 1000) begin
      step();
      cyc++;
      if (resetAll === 1'b1 && prev === 1'b0) begin
        if (rises < 3) begin
          riseAt[rises] = cyc;
          retryAt[rises] = int'(retryCnt);
        end
        rises++;
      end
      if (rxDp !== 2'b00) sawRxDp = 1'b1;
      prev = resetAll;
    end
    compared++; if (cyc !== 325) begin mismatched++; $display("[TB] FAIL retry_fail_cycle: got %0d want 325", cyc); end
    compared++; if (rises !== 3) begin mismatched++; $display("[TB] FAIL retry_pulses: got %0d want 3", rises); end
    compared++; if (riseAt[1] !== 109) begin mismatched++; $display("[TB] FAIL retry_second_rise: got %0d want 109", riseAt[1]); end
    compared++; if (riseAt[2] !== 217) begin mismatched++; $display("[TB] FAIL retry_third_rise: got %0d want 217", riseAt[2]); end
    for (int i = 0; i < 3; i++) begin
      compared++; if (retryAt[i] !== i) begin mismatched++; $display("[TB] FAIL retry_value_p%0d: got %0d want %0d", i, retryAt[i], i); end
    end
    compared++; if (busyO !== 1'b0) begin mismatched++; $display("[TB] FAIL retry_busy: got %b want 0", busyO); end
    compared++; if (resetAll !== 1'b0) begin mismatched++; $display("[TB] FAIL retry_reset_all: got %b want 0", resetAll); end
    compared++; if (retryCnt !== 4'd2) begin mismatched++; $display("[TB] FAIL retry_final: got %0d want 2", retryCnt); end
    compared++; if (sawRxDp !== 1'b0) begin mismatched++; $display("[TB] FAIL retry_rx_dp_quiet: got %b want 0", sawRxDp); end
    swAll = 1'b1;
    step();
    swAll = 1'b0;
    compared++; if (resetAll !== 1'b1) begin mismatched++; $display("[TB] FAIL restart_reset_all: got %b want 1", resetAll); end
    compared++; if (failO !== 1'b0) begin mismatched++; $display("[TB] FAIL restart_fail: got %b want 0", failO); end
    compared++; if (retryCnt !== 4'd0) begin mismatched++; $display("[TB] FAIL restart_retry: got %0d want 0", retryCnt); end
    compared++; if (busyO !== 1'b1) begin mismatched++; $display("[TB] FAIL restart_busy: got %b want 1", busyO); end
    cyc = 0;
    while (retryCnt !== 4'd1 && cyc < 300) begin
      step();
      cyc++;
    end
    compared++; if (cyc !== 108) begin mismatched++; $display("[TB] FAIL restart_retry1_cycle: got %0d want 108", cyc); end
    rxDone = 2'b11;
    txDone = 2'b11;
    cyc = 0;
    while (linkUp !== 2'b11 && cyc < 100) begin
      step();
      cyc++;
    end
    compared++; if (cyc !== 10) begin mismatched++; $display("[TB] FAIL restart_link_cycle: got %0d want 10", cyc); end
    compared++; if (retryCnt !== 4'd1) begin mismatched++; $display("[TB] FAIL restart_run_retry: got %0d want 1", retryCnt); end
  endtask

  task automatic test_escalation();
    int cyc;
    int width;
    rxDone[0] = 1'b0;
    swRx = 2'b01;
    step();
    swRx = 2'b00;
    compared++; if (rxDp !== 2'b01) begin mismatched++; $display("[TB] FAIL esc_pulse_start: got %b want 01", rxDp); end
    cyc = 0;
    while (resetAll !== 1'b1 && cyc < 300) begin
      step();
      cyc++;
    end
    compared++; if (cyc !== 108) begin mismatched++; $display("[TB] FAIL esc_cycle: got %0d want 108", cyc); end
    compared++; if (retryCnt !== 4'd1) begin mismatched++; $display("[TB] FAIL esc_retry: got %0d want 1", retryCnt); end
    compared++; if (rxDp !== 2'b00) begin mismatched++; $display("[TB] FAIL esc_rx_dp: got %b want 00", rxDp); end
    rxDone[0] = 1'b1;
    width = 0;
    while (resetAll === 1'b1 && width < 50) begin
      width++;
      step();
    end
    compared++; if (width !== PULSE) begin mismatched++; $display("[TB] FAIL esc_width: got %0d want %0d", width, PULSE); end
    cyc = 0;
    while (linkUp !== 2'b11 && cyc < 20) begin
      step();
      cyc++;
    end
    compared++; if (cyc !== 2) begin mismatched++; $display("[TB] FAIL esc_link_back: got %0d want 2", cyc); end
  endtask

  task automatic test_priority();
    int cyc;
    logic sawRxDp;
    sawRxDp = 1'b0;
    swAll = 1'b1;
    swRx = 2'b01;
    step();
    swAll = 1'b0;
    swRx = 2'b00;
    compared++; if (resetAll !== 1'b1) begin mismatched++; $display("[TB] FAIL prio_reset_all: got %b want 1", resetAll); end
    compared++; if (rxDp !== 2'b00) begin mismatched++; $display("[TB] FAIL prio_rx_dp: got %b want 00", rxDp); end
    compared++; if (retryCnt !== 4'd0) begin mismatched++; $display("[TB] FAIL prio_retry: got %0d want 0", retryCnt); end
    for (int k = 1; k < PULSE; k++) begin
      step();
      if (rxDp !== 2'b00) sawRxDp = 1'b1;
    end
    compared++; if (sawRxDp !== 1'b0) begin mismatched++; $display("[TB] FAIL prio_rx_dp_quiet: got %b want 0", sawRxDp); end
    step();
    compared++; if (resetAll !== 1'b0) begin mismatched++; $display("[TB] FAIL prio_pulse_end: got %b want 0", resetAll); end
    cyc = 0;
    while (linkUp !== 2'b11 && cyc < 20) begin
      step();
      cyc++;
    end
    compared++; if (cyc !== 2) begin mismatched++; $display("[TB] FAIL prio_link_back: got %0d want 2", cyc); end
  endtask

  task automatic test_async_reset();
    int cyc;
    swRx = 2'b10;
    step();
    swRx = 2'b00;
    step();
    step();
    compared++; if (rxDp !== 2'b10) begin mismatched++; $display("[TB] FAIL areset_mid_pulse: got %b want 10", rxDp); end
    #2;
    rstN = 1'b0;
    #1;
    compared++; if (rxDp !== 2'b00) begin mismatched++; $display("[TB] FAIL areset_rx_dp: got %b want 00", rxDp); end
    compared++; if (resetAll !== 1'b1) begin mismatched++; $display("[TB] FAIL areset_reset_all: got %b want 1", resetAll); end
    compared++; if (busyO !== 1'b1) begin mismatched++; $display("[TB] FAIL areset_busy: got %b want 1", busyO); end
    compared++; if (linkUp !== 2'b00) begin mismatched++; $display("[TB] FAIL areset_link: got %b want 00", linkUp); end
    compared++; if (recCnt !== 16'd0) begin mismatched++; $display("[TB] FAIL areset_recover: got %0d want 0", recCnt); end
    step();
    step();
    rstN = 1'b1;
    for (int k = 1; k <= PULSE; k++) step();
    compared++; if (resetAll !== 1'b0) begin mismatched++; $display("[TB] FAIL areset_restart_pulse: got %b want 0", resetAll); end
    cyc = 0;
    while (linkUp !== 2'b11 && cyc < 20) begin
      step();
      cyc++;
    end
    compared++; if (cyc !== 2) begin mismatched++; $display("[TB] FAIL areset_link_back: got %0d want 2", cyc); end
    compared++; if (failO !== 1'b0) begin mismatched++; $display("[TB] FAIL areset_fail: got %b want 0", failO); end
  endtask

  // Scenario sequence; each task leaves the DUT in RUN with both links up for the next one.
  initial begin
    $display("[TB] starting gt_reset_sequencer directed tests");
    test_reset();
    test_bringup();
    test_rx_recover();
    test_retry_fail();
    test_escalation();
    test_priority();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
